// File: rtl/cascade_stage_sequencer.sv
// Cascade stage sequencer: walks stages, issues feature indices, accumulates votes, early exit on reject.
// Optional CASCADE_SEQ_PROFILE_EN adds exit_stage / feat_total profiling outputs.
module cascade_stage_sequencer #(
    parameter int NUM_STAGES = 25,
    parameter int W_ADDR     = 5,
    parameter int W_FEAT     = 12,
    parameter int W_SUM      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     detected,
    output logic                     fc_ena,
    output logic [W_ADDR-1:0]        fc_addr,
    input  logic [W_FEAT-1:0]        fc_data,
    input  logic signed [W_SUM-1:0]  thr_data,
    output logic                     feat_valid,
    input  logic                     feat_ready,
    output logic [W_FEAT-1:0]        feat_idx,
    input  logic                     res_valid,
    input  logic signed [W_SUM-1:0]  res_data
`ifdef CASCADE_SEQ_PROFILE_EN
    ,
    output logic [W_ADDR:0]          exit_stage,
    output logic [W_FEAT-1:0]        feat_total
`endif
);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, ISSUE, EVAL, FINISH} state_t;

    localparam logic signed [W_SUM-1:0] SUM_MAX = {1'b0, {(W_SUM-1){1'b1}}};
    localparam logic signed [W_SUM-1:0] SUM_MIN = {1'b1, {(W_SUM-1){1'b0}}};

    state_t                   state;
    logic [W_ADDR-1:0]        stage;
    logic [W_FEAT-1:0]        base;
    logic [W_FEAT-1:0]        stage_end;
    logic [W_FEAT-1:0]        received;
    logic signed [W_SUM-1:0]  thr;
    logic signed [W_SUM-1:0]  sum;

    logic [W_FEAT-1:0]        next_issued;
    logic [W_FEAT-1:0]        next_received;
    logic signed [W_SUM:0]    sum_ext;
    logic signed [W_SUM-1:0]  sum_sat;
    logic                     issue_fire;
    logic                     res_take;

    assign next_issued   = feat_idx + 1'b1;
    assign next_received = received + 1'b1;
    assign issue_fire    = feat_valid && feat_ready;
    assign res_take      = res_valid && (received < stage_end);

    // One extra bit of headroom: overflow shows up as disagreement of the top two bits.
    assign sum_ext = {sum[W_SUM-1], sum} + {res_data[W_SUM-1], res_data};

    always_comb begin
        sum_sat = sum_ext[W_SUM-1:0];
        if (sum_ext[W_SUM] != sum_ext[W_SUM-1])
            sum_sat = sum_ext[W_SUM] ? SUM_MIN : SUM_MAX;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            detected   <= 1'b0;
            fc_ena     <= 1'b0;
            fc_addr    <= '0;
            feat_valid <= 1'b0;
            feat_idx   <= '0;
            stage      <= '0;
            base       <= '0;
            stage_end  <= '0;
            received   <= '0;
            thr        <= '0;
            sum        <= '0;
`ifdef CASCADE_SEQ_PROFILE_EN
            exit_stage <= '0;
            feat_total <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        detected <= 1'b0;
                        stage    <= '0;
                        base     <= '0;
                        fc_ena   <= 1'b1;
                        fc_addr  <= '0;
                        state    <= FETCH;
`ifdef CASCADE_SEQ_PROFILE_EN
                        feat_total <= '0;
`endif
                    end
                end
                FETCH: begin
                    fc_ena <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    stage_end <= fc_data;
                    thr       <= thr_data;
                    feat_idx  <= base;
                    received  <= base;
                    sum       <= '0;
                    if (fc_data <= base) begin
                        state <= EVAL;
                    end else begin
                        feat_valid <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Issue and result sides advance independently in the same cycle.
                    if (issue_fire) begin
                        feat_idx   <= next_issued;
                        feat_valid <= (next_issued < stage_end);
`ifdef CASCADE_SEQ_PROFILE_EN
                        feat_total <= feat_total + 1'b1;
`endif
                    end
                    if (res_take) begin
                        sum      <= sum_sat;
                        received <= next_received;
                        if (next_received == stage_end)
                            state <= EVAL;
                    end
                end
                EVAL: begin
                    if (sum >= thr) begin
                        if (stage == W_ADDR'(NUM_STAGES - 1)) begin
                            detected <= 1'b1;
                            done     <= 1'b1;
                            state    <= FINISH;
`ifdef CASCADE_SEQ_PROFILE_EN
                            exit_stage <= (W_ADDR+1)'(NUM_STAGES);
`endif
                        end else begin
                            stage   <= stage + 1'b1;
                            base    <= stage_end;
                            fc_ena  <= 1'b1;
                            fc_addr <= stage + 1'b1;
                            state   <= FETCH;
                        end
                    end else begin
                        detected <= 1'b0;
                        done     <= 1'b1;
                        state    <= FINISH;
`ifdef CASCADE_SEQ_PROFILE_EN
                        exit_stage <= {1'b0, stage};
`endif
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cascade_stage_sequencer.sv
// Scoreboard bench for cascade_stage_sequencer: ROM/evaluator models, queued expectations, decoupled monitor.
// Profile outputs are checked when CASCADE_SEQ_PROFILE_EN is defined.
module tb_cascade_stage_sequencer;

    localparam int NS = 25;
    localparam int WA = 5;
    localparam int WF = 12;
    localparam int WS = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 busy, done, detected, fc_ena;
    logic [WA-1:0]        fc_addr;
    logic [WF-1:0]        fc_data = '0;
    logic signed [WS-1:0] thr_data = '0;
    logic                 feat_valid;
    logic                 feat_ready;
    logic [WF-1:0]        feat_idx;
    logic                 res_valid;
    logic signed [WS-1:0] res_data;
`ifdef CASCADE_SEQ_PROFILE_EN
    logic [WA:0]          exit_stage;
    logic [WF-1:0]        feat_total;
`endif

    cascade_stage_sequencer #(.NUM_STAGES(NS), .W_ADDR(WA), .W_FEAT(WF), .W_SUM(WS)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .detected(detected),
        .fc_ena(fc_ena), .fc_addr(fc_addr), .fc_data(fc_data), .thr_data(thr_data),
        .feat_valid(feat_valid), .feat_ready(feat_ready), .feat_idx(feat_idx),
        .res_valid(res_valid), .res_data(res_data)
`ifdef CASCADE_SEQ_PROFILE_EN
        , .exit_stage(exit_stage), .feat_total(feat_total)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { bit det; int exit_stage; int total; } res_t;
    typedef struct { int idx; longint due; } pend_t;

    int     ends[NS];
    int     thrs[NS];
    int     votes[4096];
    int     exp_idx[$];
    res_t   exp_done[$];
    pend_t  pend[$];
    int     errors = 0;
    int     checks = 0;
    int     n_done = 0;
    int     n_win  = 0;
    bit     stall  = 1'b0;

    // Registered ROM pair sharing one address and enable.
    always @(posedge clk)
        if (fc_ena && fc_addr < NS) begin
            fc_data  <= WF'(ends[fc_addr]);
            thr_data <= WS'(thrs[fc_addr]);
        end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference: run the cascade directly over the tables with integer sums and clamping.
    function automatic res_t model();
        res_t r;
        int   base;
        int   sum;
        base = 0;
        r.det = 1'b1;
        r.exit_stage = NS;
        r.total = 0;
        for (int s = 0; s < NS; s++) begin
            sum = 0;
            for (int f = base; f < ends[s]; f++) begin
                sum += votes[f];
                if (sum > 32767)  sum = 32767;
                if (sum < -32768) sum = -32768;
            end
            base = ends[s];
            r.total = ends[s];
            if (sum < thrs[s]) begin
                r.det = 1'b0;
                r.exit_stage = s;
                return r;
            end
        end
        return r;
    endfunction

    function automatic void base_rom();
        ends[0] = 9;
        ends[1] = 25;
        ends[2] = 52;
        for (int i = 3; i < NS; i++) ends[i] = 52 + (2861 * (i - 2)) / 22;
        for (int i = 0; i < NS; i++) thrs[i] = 0;
        for (int f = 0; f < 4096; f++) votes[f] = 1;
    endfunction

    // Evaluator model + monitor: drives ready/results, checks every issue and every done.
    initial begin
        longint cyc = 0;
        longint last_due = 0;
        bit     stalled = 1'b0;
        int     sidx = 0;
        int     e;
        res_t   r;
        feat_ready = 1'b0;
        res_valid  = 1'b0;
        res_data   = '0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (rst) begin
                exp_idx.delete();
                exp_done.delete();
                feat_ready = 1'b0;
                res_valid  = 1'b0;
                stalled    = 1'b0;
                continue;
            end
            if (stalled)
                chk("stall_hold", feat_valid ? int'(feat_idx) : -1, sidx);
            if (done) begin
                n_done++;
                chk("done_expected", exp_done.size() > 0, 1);
                if (exp_done.size() > 0) begin
                    r = exp_done.pop_front();
                    chk("detected", detected, r.det);
`ifdef CASCADE_SEQ_PROFILE_EN
                    chk("exit_stage", exit_stage, r.exit_stage);
                    chk("feat_total", feat_total, r.total);
`endif
                end
            end
            feat_ready = stall ? ($urandom % 3 != 0) : 1'b1;
            if (feat_valid && feat_ready) begin
                e = -1;
                if (exp_idx.size() > 0) e = exp_idx.pop_front();
                chk("feat_idx", feat_idx, e);
                begin
                    pend_t p;
                    p.idx = feat_idx;
                    p.due = cyc + 1 + (stall ? longint'($urandom % 6) : 0);
                    if (p.due <= last_due) p.due = last_due + 1;
                    last_due = p.due;
                    pend.push_back(p);
                end
                stalled = 1'b0;
            end else begin
                stalled = feat_valid;
                sidx    = feat_idx;
            end
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                res_valid = 1'b1;
                res_data  = WS'(votes[pend[0].idx]);
                void'(pend.pop_front());
            end else begin
                res_valid = 1'b0;
            end
        end
    end

    task automatic run_window(input bit stray);
        res_t r;
        int   n;
        r = model();
        for (int i = 0; i < r.total; i++) exp_idx.push_back(i);
        exp_done.push_back(r);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("lat_busy", busy, 1);
        chk("lat_fc_ena", fc_ena, 1);
        chk("lat_fc_addr", fc_addr, 0);
        chk("lat_detected_clr", detected, 0);
        @(negedge clk);
        chk("lat_no_valid_t2", feat_valid, 0);
        @(negedge clk);
        chk("lat_valid_t3", feat_valid, 1);
        chk("lat_idx_t3", feat_idx, 0);
        n = 0;
        while (!done && n < 12000) begin
            @(negedge clk);
            start = stray && feat_valid && ($urandom % 40 == 0);
            n++;
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_drop", busy, 0);
        chk("detected_hold", detected, r.det);
        chk("all_issued", exp_idx.size(), 0);
        n_win++;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        base_rom();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_detected", detected, 0);
        chk("rst_fc_ena", fc_ena, 0);
        chk("rst_fc_addr", fc_addr, 0);
        chk("rst_feat_valid", feat_valid, 0);
        chk("rst_feat_idx", feat_idx, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full pass, every vote +1, no stalls.
        run_window(1'b0);
        // Stage 0 rejects.
        thrs[0] = 100;
        run_window(1'b0);
        // Full pass again under stalls, delayed results and stray starts.
        thrs[0] = 0;
        stall = 1'b1;
        run_window(1'b1);
        // Saturation: 9 x 0x7FFF clamps to 32767 and meets threshold 32767.
        for (int f = 0; f < 4096; f++) votes[f] = 32767;
        thrs[0] = 32767;
        run_window(1'b0);
        // Empty stage passes with threshold 0, rejects with threshold 1.
        base_rom();
        ends[1] = ends[0];
        run_window(1'b0);
        thrs[1] = 1;
        run_window(1'b0);

        // Reset mid-ISSUE in stage 3.
        base_rom();
        for (int i = 0; i < 2913; i++) exp_idx.push_back(i);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!(feat_valid && feat_idx >= WF'(ends[2] + 3)) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_stage3", feat_valid && feat_idx >= WF'(ends[2] + 3), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_feat_valid", feat_valid, 0);
        chk("abort_fc_ena", fc_ena, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        run_window(1'b1);

        // Randomized votes and thresholds, small then full-range votes.
        for (int w = 0; w < 6; w++) begin
            int prev;
            prev = 0;
            for (int f = 0; f < 4096; f++)
                votes[f] = (w < 4) ? int'($urandom_range(0, 8)) - 3 : int'($urandom_range(0, 65535)) - 32768;
            for (int s = 0; s < NS; s++) begin
                int sz;
                sz = ends[s] - prev;
                prev = ends[s];
                thrs[s] = (w < 4) ? int'($urandom_range(0, sz + sz / 4 + 1)) - sz / 4
                                  : int'($urandom_range(0, 40000)) - 20000;
            end
            run_window(1'b1);
        end

        chk("done_count", n_done, n_win);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cascade_stage_sequencer.md
Name: cascade_stage_sequencer

Overview:
Sits directly downstream of the per-stage cumulative feature-count ROM in the cascade classifier. For each detection window it walks stages 0..NUM_STAGES-1 in order. For every stage it reads that stage's cumulative feature end index and its stage threshold, and issues the stage's feature indices to the feature evaluator. It accumulates the returned weak-classifier votes and decides pass/reject per stage, with early exit on the first rejecting stage.

Parameters:
NUM_STAGES, 25, number of cascade stages (ROM depth)
W_ADDR, 5, stage index / ROM address width
W_FEAT, 12, feature index width; must hold the largest cumulative count (0xb61)
W_SUM, 16, signed stage accumulator and threshold width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin evaluation of one window; sampled only in IDLE
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse, final decision valid
detected  out  1  valid with done: 1 = all stages passed, 0 = rejected
fc_ena  out  1  ROM read enable (feature-count ROM and threshold ROM share it)
fc_addr  out  W_ADDR  stage index to ROM
fc_data  in  W_FEAT  cumulative feature end index; registered ROM, 1-cycle latency
thr_data  in  W_SUM  signed stage threshold; same address and latency as fc_data
feat_valid  out  1  feature index valid
feat_ready  in  1  evaluator accepts index
feat_idx  out  W_FEAT  feature index
res_valid  in  1  one signed weak-classifier vote returned; results arrive in issue order, no backpressure
res_data  in  W_SUM  signed vote value

Behaviour:
- Synchronous active-high reset on clk only. Every state register and counter is cleared. Reset values: busy=0, done=0, detected=0, fc_ena=0, fc_addr=0, feat_valid=0, feat_idx=0. State goes to IDLE.
- Reset mid-operation aborts immediately. Outstanding results arriving afterwards are ignored.
- Stage i covers features [end(i-1), end(i)). end(-1)=0 and end(i)=fc_data read at address i.
- FSM states: IDLE, FETCH, WAIT, ISSUE, EVAL, FINISH.
- IDLE: if start=1, set stage=0, base=0, go to FETCH. start is ignored in all other states.
- FETCH: drive fc_ena=1 and fc_addr=stage for exactly one cycle, then go to WAIT.
- WAIT: latch end=fc_data and thr=thr_data. Set issued=base, received=base, sum=0. Go to ISSUE. If end<=base (empty stage), go directly to EVAL instead.
- ISSUE, issue side: feat_valid=1 while issued<end, with feat_idx=issued. On feat_valid&feat_ready, increment issued. feat_idx and feat_valid hold stable while stalled. feat_valid deasserts in the cycle issued reaches end.
- ISSUE, result side: on res_valid with received<end, sum is the signed saturating add of sum and res_data, clamped to [-2^(W_SUM-1), 2^(W_SUM-1)-1]. received then increments. res_valid with received>=end is ignored.
- A result returning in the same cycle as an issue is legal; both counters update independently.
- Leave ISSUE for EVAL when received==end. This covers the same cycle as the last result; the sum used includes that result.
- EVAL (1 cycle): pass = (sum >= thr), signed compare.
  - pass and stage==NUM_STAGES-1: detected=1, go to FINISH.
  - pass otherwise: stage+1, base=end, go to FETCH.
  - fail: detected=0, go to FINISH.
- FINISH: done=1 for one cycle, busy=0 next cycle, return to IDLE. detected holds its value until the next accepted start, which clears it.
- Latency: start sampled at cycle t. busy=1 and fc_ena=1 at t+1. First feat_valid at t+3. done appears 2 cycles after the final result of the deciding stage (EVAL, then FINISH).
- feat_idx is monotonic within a window, with no gaps or repeats across stage boundaries.

Optional Feature:
Macro CASCADE_SEQ_PROFILE_EN.
- Defined: adds outputs exit_stage (W_ADDR+1 bits) and feat_total (W_FEAT bits), both valid with done.
  - exit_stage = rejecting stage index, or NUM_STAGES if detected.
  - feat_total = number of features issued in the window.
  - Both reset to 0.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- ROM loaded with cumulative counts 9,25,52,…,0xb61; all thresholds 0; every vote +1 -> feat_idx 0..0xb60 issued in order (2913 total), done with detected=1.
- Stage 0 threshold 100, votes +1 -> only feat_idx 0..8 issued, done with detected=0; with the macro, exit_stage=0 and feat_total=9.
- feat_ready toggled pseudo-randomly and results delayed 0–5 cycles -> feat_idx held while stalled, no skip or duplicate, same decision as the zero-stall run.
- Stage 0 votes all 0x7FFF with threshold 0x7FFF -> sum saturates at 32767 rather than wrapping; stage passes.
- rst asserted mid-ISSUE during stage 3 -> next cycle busy=0 and feat_valid=0; a new start restarts at fc_addr=0, feat_idx=0.
- start pulsed while busy -> ignored, only one done per accepted start; start sampled in IDLE -> fc_ena at t+1, first feat_valid at t+3.
